// File: rtl/input_conditioner.sv
// input_conditioner
// -----------------
// Front-end for the LED shifter stage. Every raw switch and push-button goes
// through a two-flop synchroniser. It then goes through a debounce counter,
// which accepts a new level only after that level has persisted for DEB_LIMIT
// consecutive cycles. Buttons also produce a registered single-cycle pulse on
// each accepted 0->1 transition.
//
// Build option:
//   INCOND_FALL_EDGE_EN - when defined, adds o_btn_fall. This is a registered
//                         single-cycle pulse on each accepted 1->0 transition
//                         of a button.
//
// Ports:
//   clock       - system clock, all logic on the rising edge
//   ck_rst      - synchronous active-high reset, clears every register
//   i_btn       - raw asynchronous push-buttons   [NB_BTN]
//   i_sw        - raw asynchronous switches       [NB_SW]
//   o_btn       - debounced button levels         [NB_BTN]
//   o_btn_rise  - one-cycle pulse on accepted 0->1 per button [NB_BTN]
//   o_sw        - debounced switch levels         [NB_SW]
//   o_btn_fall  - one-cycle pulse on accepted 1->0 per button [NB_BTN]
//                 (present only with INCOND_FALL_EDGE_EN)

module input_conditioner #(
  parameter int NB_BTN    = 4,
  parameter int NB_SW     = 4,
  parameter int NB_DEB    = 20,
  parameter int DEB_LIMIT = 1000000
) (
  input  logic              clock,
  input  logic              ck_rst,
  input  logic [NB_BTN-1:0] i_btn,
  input  logic [NB_SW-1:0]  i_sw,
  output logic [NB_BTN-1:0] o_btn,
  output logic [NB_BTN-1:0] o_btn_rise,
  output logic [NB_SW-1:0]  o_sw
`ifdef INCOND_FALL_EDGE_EN
  ,
  output logic [NB_BTN-1:0] o_btn_fall
`endif
);

  localparam int NB_CH = NB_BTN + NB_SW;

  // Terminal count. The counter stops here, so it can never wrap.
  localparam logic [NB_DEB-1:0] LIMIT_M1 = NB_DEB'(DEB_LIMIT - 1);

  // Buttons occupy the low channel indices and switches the high ones. This
  // lets one generate loop handle both kinds of channel.
  logic [NB_CH-1:0] raw;
  logic [NB_CH-1:0] lvl;

  assign raw = {i_sw, i_btn};

  for (genvar i = 0; i < NB_CH; i++) begin : g_ch
    logic              s1;
    logic              s2;
    logic              stb;
    logic [NB_DEB-1:0] cnt;
    logic              accept;

    // The synchronised value has differed from the stable level for
    // DEB_LIMIT consecutive cycles. It is taken on this edge.
    assign accept = (s2 != stb) && (cnt == LIMIT_M1);

    // Synchroniser and debounce counter. Any cycle where s2 agrees with the
    // stable level restarts qualification from zero. Because of this, a
    // glitch shorter than DEB_LIMIT cycles never reaches the output.
    always_ff @(posedge clock) begin
      if (ck_rst) begin
        s1  <= 1'b0;
        s2  <= 1'b0;
        stb <= 1'b0;
        cnt <= '0;
      end else begin
        s1 <= raw[i];
        s2 <= s1;
        if (s2 == stb) begin
          cnt <= '0;
        end else if (accept) begin
          stb <= s2;
          cnt <= '0;
        end else begin
          cnt <= cnt + NB_DEB'(1);
        end
      end
    end

    assign lvl[i] = stb;

    if (i < NB_BTN) begin : g_btn
      logic rise_q;

      // The pulse is registered on the same edge that updates stb. It is
      // therefore high in exactly the first cycle where the new level is
      // visible on o_btn.
      always_ff @(posedge clock) begin
        if (ck_rst) begin
          rise_q <= 1'b0;
        end else begin
          rise_q <= accept & s2;
        end
      end

      assign o_btn_rise[i] = rise_q;

`ifdef INCOND_FALL_EDGE_EN
      logic fall_q;

      // Release counterpart of rise_q, with identical timing.
      always_ff @(posedge clock) begin
        if (ck_rst) begin
          fall_q <= 1'b0;
        end else begin
          fall_q <= accept & ~s2;
        end
      end

      assign o_btn_fall[i] = fall_q;
`endif
    end
  end

  assign o_btn = lvl[NB_BTN-1:0];
  assign o_sw  = lvl[NB_CH-1:NB_BTN];

endmodule

// File: tb/tb_input_conditioner.sv
// tb_input_conditioner
// --------------------
// Directed bench for input_conditioner, using DEB_LIMIT=4 and NB_DEB=3. With
// these values a clean raw change sampled on edge k appears on the outputs
// after edge k+5. Inputs are driven and outputs are sampled 1 time unit after
// each rising edge.

module tb_input_conditioner;

  logic       clock;
  logic       ck_rst;
  logic [3:0] i_btn;
  logic [3:0] i_sw;
  logic [3:0] o_btn;
  logic [3:0] o_btn_rise;
  logic [3:0] o_sw;
`ifdef INCOND_FALL_EDGE_EN
  logic [3:0] o_btn_fall;
`endif

  int tests_run = 0;
  int tests_failed = 0;
  int rise_cnt [4];
  int snap [4];
  logic held;

  input_conditioner #(
    .NB_BTN(4),
    .NB_SW(4),
    .NB_DEB(3),
    .DEB_LIMIT(4)
  ) dut (
    .clock(clock),
    .ck_rst(ck_rst),
    .i_btn(i_btn),
    .i_sw(i_sw),
    .o_btn(o_btn),
    .o_btn_rise(o_btn_rise),
    .o_sw(o_sw)
`ifdef INCOND_FALL_EDGE_EN
    ,
    .o_btn_fall(o_btn_fall)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic applyStimulus(input logic [3:0] btn, input logic [3:0] sw);
    i_btn = btn;
    i_sw  = sw;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
    end
  endtask

  // Advance one clock and accumulate the rise pulses seen per button.
  task automatic tick(input int n);
    for (int c = 0; c < n; c++) begin
      @(posedge clock);
      #1;
      for (int b = 0; b < 4; b++) rise_cnt[b] += int'(o_btn_rise[b]);
    end
  endtask

  initial begin
    for (int b = 0; b < 4; b++) rise_cnt[b] = 0;
    ck_rst = 1'b1;
    applyStimulus(4'b0000, 4'b0000);
    tick(2);
    checkOutput("reset_btn", 32'(o_btn), 32'h0);
    checkOutput("reset_rise", 32'(o_btn_rise), 32'h0);
    checkOutput("reset_sw", 32'(o_sw), 32'h0);
    ck_rst = 1'b0;
    tick(2);

    // 1. Clean press on button 0.
    applyStimulus(4'b0001, 4'b0000);
    tick(5);
    checkOutput("t1_before_accept", 32'(o_btn), 32'h0);
    checkOutput("t1_no_early_rise", 32'(o_btn_rise), 32'h0);
    tick(1);
    checkOutput("t1_btn_accepted", 32'(o_btn), 32'h1);
    checkOutput("t1_rise_pulse", 32'(o_btn_rise), 32'h1);
    tick(1);
    checkOutput("t1_rise_cleared", 32'(o_btn_rise), 32'h0);
    checkOutput("t1_btn_held", 32'(o_btn), 32'h1);
    checkOutput("t1_sw_quiet", 32'(o_sw), 32'h0);

    // 2. Bounce on button 1: 1,1,1,0 then steady 1.
    snap[1] = rise_cnt[1];
    held = 1'b1;
    for (int c = 0; c < 4; c++) begin
      applyStimulus((c == 3) ? 4'b0001 : 4'b0011, 4'b0000);
      tick(1);
      if (o_btn != 4'b0001) held = 1'b0;
    end
    applyStimulus(4'b0011, 4'b0000);
    for (int c = 0; c < 5; c++) begin
      tick(1);
      if (o_btn != 4'b0001) held = 1'b0;
    end
    checkOutput("t2_no_change_in_bounce", 32'(held), 32'h1);
    tick(1);
    checkOutput("t2_btn_accepted", 32'(o_btn), 32'h3);
    checkOutput("t2_rise_pulse", 32'(o_btn_rise), 32'h2);
    tick(1);
    checkOutput("t2_one_pulse", 32'(rise_cnt[1] - snap[1]), 32'h1);

    // 3. Press button 2, then a 3-cycle release glitch, then a real release.
    applyStimulus(4'b0111, 4'b0000);
    tick(6);
    checkOutput("t3_btn2_pressed", 32'(o_btn), 32'h7);
    tick(1);
    snap[2] = rise_cnt[2];
    held = 1'b1;
    applyStimulus(4'b0011, 4'b0000);
    for (int c = 0; c < 3; c++) begin
      tick(1);
      if (o_btn[2] != 1'b1) held = 1'b0;
    end
    applyStimulus(4'b0111, 4'b0000);
    for (int c = 0; c < 8; c++) begin
      tick(1);
      if (o_btn[2] != 1'b1) held = 1'b0;
    end
    checkOutput("t3_glitch_ignored", 32'(held), 32'h1);
    applyStimulus(4'b0011, 4'b0000);
    tick(5);
    checkOutput("t3_release_pending", 32'(o_btn), 32'h7);
    tick(1);
    checkOutput("t3_released", 32'(o_btn), 32'h3);
    checkOutput("t3_no_rise_on_release", 32'(o_btn_rise), 32'h0);
    checkOutput("t3_rise_count", 32'(rise_cnt[2] - snap[2]), 32'h0);

    // 4. Reset arrives while buttons 2 and 3 are still qualifying.
    applyStimulus(4'b1111, 4'b0000);
    tick(4);
    checkOutput("t4_pending", 32'(o_btn), 32'h3);
    ck_rst = 1'b1;
    tick(1);
    checkOutput("t4_rst1_btn", 32'(o_btn), 32'h0);
    checkOutput("t4_rst1_rise", 32'(o_btn_rise), 32'h0);
    tick(1);
    checkOutput("t4_rst2_btn", 32'(o_btn), 32'h0);
    checkOutput("t4_rst2_sw", 32'(o_sw), 32'h0);
    ck_rst = 1'b0;
    for (int b = 0; b < 4; b++) snap[b] = rise_cnt[b];
    tick(5);
    checkOutput("t4_requalifying", 32'(o_btn), 32'h0);
    tick(1);
    checkOutput("t4_btn_accepted", 32'(o_btn), 32'hf);
    checkOutput("t4_rise_pulse", 32'(o_btn_rise), 32'hf);
    tick(1);
    checkOutput("t4_rise_cleared", 32'(o_btn_rise), 32'h0);
    checkOutput("t4_one_pulse_b3", 32'(rise_cnt[3] - snap[3]), 32'h1);

    // 5. Clear everything, then buttons and switches change together.
    applyStimulus(4'b0000, 4'b0000);
    tick(7);
    checkOutput("t5_cleared", 32'(o_btn), 32'h0);
    applyStimulus(4'b1111, 4'b1010);
    tick(5);
    checkOutput("t5_btn_pending", 32'(o_btn), 32'h0);
    checkOutput("t5_sw_pending", 32'(o_sw), 32'h0);
    tick(1);
    checkOutput("t5_btn_accepted", 32'(o_btn), 32'hf);
    checkOutput("t5_sw_accepted", 32'(o_sw), 32'ha);
    checkOutput("t5_rise_all", 32'(o_btn_rise), 32'hf);
    tick(1);
    checkOutput("t5_rise_cleared", 32'(o_btn_rise), 32'h0);

`ifdef INCOND_FALL_EDGE_EN
    // 6. Release button 0 and look for the fall pulse.
    applyStimulus(4'b1110, 4'b1010);
    tick(5);
    checkOutput("t6_fall_pending", 32'(o_btn_fall), 32'h0);
    tick(1);
    checkOutput("t6_btn_released", 32'(o_btn), 32'he);
    checkOutput("t6_fall_pulse", 32'(o_btn_fall), 32'h1);
    checkOutput("t6_no_rise", 32'(o_btn_rise), 32'h0);
    tick(1);
    checkOutput("t6_fall_cleared", 32'(o_btn_fall), 32'h0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
